led_uart_mmio: RTL and testbench
================================

Name: led_uart_mmio

Overview:
- Memory-mapped I/O peripheral on the CPU's MMIO bus.
- Provides an `IO_LED_WIDTH`-bit LED output register and a transmit-only 8N1 UART with a status register.
- Single-cycle request interface; fixed latency for every access.
- Addresses, widths and offsets come from `defines.vh`/`interface.vh`.

Parameters:
- UART_DIV, default 868: clock cycles per UART bit. Legal range is ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mmio_req  in  1  access request, valid for one cycle.
- mmio_we  in  1  1 = write, 0 = read; qualified by mmio_req.
- mmio_addr  in  `ADDR_W`  byte address of the access.
- mmio_wdata  in  `XLEN`  write data.
- mmio_rdata  out  `XLEN`  read data, registered.
- mmio_ready  out  1  access-complete pulse, registered.
- led_out  out  `IO_LED_WIDTH`  LED drive, equal to the LED register.
- uart_tx  out  1  serial TX line; idles high.

Behaviour:
- Register map, full-address compare against `IO_BASE_ADDR` + offset:
  - LED at `IO_LED_OFFSET`: read/write. Writes take wdata[`IO_LED_WIDTH`-1:0]. Reads return the value zero-extended.
  - UART_TX at `IO_UART_TX_OFFSET`: write-only. Writes take wdata[7:0]. Reads return 0.
  - UART_STAT at `IO_UART_STAT_OFFSET`: read-only. Bit `IO_UART_STAT_BUSY_BIT` = busy; all other bits 0. Writes are ignored.
  - Unmapped addresses: reads return 0; writes are ignored.
- Handshake:
  - A request is sampled on a rising edge with mmio_req=1.
  - mmio_ready=1 for exactly the following cycle.
  - For reads, mmio_rdata is valid in that same cycle and holds the selected register value as of the sampling edge. Otherwise it holds its last value.
  - A new request may be issued every cycle; there is no backpressure.
- Write timing: the LED register, and hence led_out, updates at the sampling edge, so it is visible the next cycle.
- UART transmitter:
  - Two states, IDLE and SEND.
  - A TX write in IDLE loads a 10-bit frame: start bit 0, data bits LSB first, stop bit 1. The block enters SEND with busy=1 from the next cycle.
  - Each bit is held for exactly UART_DIV cycles using a baud counter that counts 0 to UART_DIV-1.
  - After the stop bit completes, the block returns to IDLE with busy=0 and uart_tx=1.
  - Total busy time is 10×UART_DIV cycles.
  - A TX write while busy is dropped. The frame in progress is unaffected.
  - A TX write in the same cycle a frame finishes is dropped; busy is still 1 at that edge.
  - uart_tx is driven from a register, so it is glitch-free.
- Reset, synchronous and usable mid-frame:
  - led_out=0, uart_tx=1, busy=0, state IDLE.
  - Baud and bit counters cleared.
  - mmio_ready=0, mmio_rdata=0.
  - A frame in progress is aborted and the line returns high immediately.
- A request on the same edge that reset is asserted is ignored.

Optional Feature:
- Macro: LED_UART_TXCNT_EN.
- When defined: UART_STAT[31:16] is a 16-bit count of accepted (not dropped) TX writes. The count wraps 0xFFFF→0, clears on reset, and is read-only.
- When not defined: UART_STAT[31:16] reads 0 and no counter logic exists.

Test Plan:
- Reset held 4 cycles, then released → led_out=0x0000, uart_tx=1, UART_STAT busy=0.
- Write LED 0x0000_A5A5, then read LED → rdata[15:0]=0xA5A5, led_out=0xA5A5, mmio_ready pulses one cycle per access.
- 20 random 16-bit LED writes, each followed by a readback → each readback and led_out match the value written.
- With UART_DIV=8, write TX 0x55, read STAT next cycle → busy=1. uart_tx shows 0,1,0,1,0,1,0,1,0,1, each level held 8 cycles. After 10×8+4 cycles, busy=0 and uart_tx=1.
- With UART_DIV=8, write TX 0x55, then TX 0xFF while busy → second byte is dropped and the line returns idle after 80 cycles. With LED_UART_TXCNT_EN defined, STAT[31:16]=1.
- Assert rst mid-frame → uart_tx=1 and busy=0 on the next cycle. Reads of an unmapped address and of UART_TX return 0.

Source files
------------

// File: rtl/led_uart_mmio.sv
// LED output register plus transmit-only 8N1 UART behind a single-cycle MMIO port.
// Optional: define LED_UART_TXCNT_EN to expose a 16-bit accepted-TX-write count in UART_STAT[31:16].

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_LED_WIDTH
`define IO_LED_WIDTH 16
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef IO_LED_OFFSET
`define IO_LED_OFFSET 32'h0000_0000
`endif
`ifndef IO_UART_TX_OFFSET
`define IO_UART_TX_OFFSET 32'h0000_0004
`endif
`ifndef IO_UART_STAT_OFFSET
`define IO_UART_STAT_OFFSET 32'h0000_0008
`endif
`ifndef IO_UART_STAT_BUSY_BIT
`define IO_UART_STAT_BUSY_BIT 0
`endif

module led_uart_mmio #(
  parameter int UART_DIV = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mmio_req,
  input  logic                     mmio_we,
  input  logic [`ADDR_W-1:0]       mmio_addr,
  input  logic [`XLEN-1:0]         mmio_wdata,
  output logic [`XLEN-1:0]         mmio_rdata,
  output logic                     mmio_ready,
  output logic [`IO_LED_WIDTH-1:0] led_out,
  output logic                     uart_tx
);

  localparam int AW     = `ADDR_W;
  localparam int XW     = `XLEN;
  localparam int LW     = `IO_LED_WIDTH;
  localparam int BAUD_W = $clog2(UART_DIV);

  localparam logic [AW-1:0] LED_ADDR  = AW'(`IO_BASE_ADDR + `IO_LED_OFFSET);
  localparam logic [AW-1:0] TX_ADDR   = AW'(`IO_BASE_ADDR + `IO_UART_TX_OFFSET);
  localparam logic [AW-1:0] STAT_ADDR = AW'(`IO_BASE_ADDR + `IO_UART_STAT_OFFSET);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(UART_DIV - 1);

  // Handshake: a request is taken on any rising edge with mmio_req=1 (no
  // backpressure); mmio_ready is high for exactly the next cycle and, for
  // reads, mmio_rdata carries the register value as of the sampling edge.

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_state_e;

  uart_state_e       state_q, state_d;
  logic [9:0]        frame_q, frame_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic [LW-1:0]     led_q, led_d;
  logic [XW-1:0]     rdata_q, rdata_d;
  logic              ready_q, ready_d;

  logic          req_wr, req_rd;
  logic          hit_led, hit_tx, hit_stat;
  logic          busy;
  logic          tx_accept;
  logic [XW-1:0] stat_val;
  logic [XW-1:0] rd_val;

  assign req_wr    = mmio_req & mmio_we;
  assign req_rd    = mmio_req & ~mmio_we;
  assign hit_led   = (mmio_addr == LED_ADDR);
  assign hit_tx    = (mmio_addr == TX_ADDR);
  assign hit_stat  = (mmio_addr == STAT_ADDR);
  assign busy      = (state_q == SEND);
  assign tx_accept = req_wr & hit_tx & ~busy;

`ifdef LED_UART_TXCNT_EN
  logic [15:0] txcnt_q, txcnt_d;

  always_comb begin
    txcnt_d = txcnt_q;
    if (tx_accept) begin
      txcnt_d = txcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txcnt_q <= '0;
    end else begin
      txcnt_q <= txcnt_d;
    end
  end
`endif

  always_comb begin
    stat_val = '0;
    stat_val[`IO_UART_STAT_BUSY_BIT] = busy;
`ifdef LED_UART_TXCNT_EN
    stat_val[31:16] = txcnt_q;
`endif
  end

  always_comb begin
    rd_val = '0;
    if (hit_led) begin
      rd_val[LW-1:0] = led_q;
    end else if (hit_stat) begin
      rd_val = stat_val;
    end
  end

  always_comb begin
    led_d   = led_q;
    rdata_d = rdata_q;
    ready_d = mmio_req;
    if (req_wr && hit_led) begin
      led_d = mmio_wdata[LW-1:0];
    end
    if (req_rd) begin
      rdata_d = rd_val;
    end
  end

  // frame_q holds the 10-bit frame shifted right as bits go out; tx_q is
  // loaded with the next bit in the same edge so the line stays registered.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (tx_accept) begin
          frame_d = {1'b1, mmio_wdata[7:0], 1'b0};
          tx_d    = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {1'b1, frame_q[9:1]};
            tx_d    = frame_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      led_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      led_q   <= led_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign mmio_rdata = rdata_q;
  assign mmio_ready = ready_q;
  assign led_out    = led_q;
  assign uart_tx    = tx_q;

  // Upper write-data bits and the already-sent start bit are never consumed.
  logic unused_bits;
  assign unused_bits = ^{mmio_wdata[XW-1:LW], frame_q[0]};

endmodule

// File: tb/tb_led_uart_mmio.sv
// Bench for led_uart_mmio with UART_DIV=8: register vectors, random LED traffic,
// UART frame waveform, dropped writes and mid-frame reset.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef IO_LED_WIDTH
`define IO_LED_WIDTH 16
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef IO_LED_OFFSET
`define IO_LED_OFFSET 32'h0000_0000
`endif
`ifndef IO_UART_TX_OFFSET
`define IO_UART_TX_OFFSET 32'h0000_0004
`endif
`ifndef IO_UART_STAT_OFFSET
`define IO_UART_STAT_OFFSET 32'h0000_0008
`endif
`ifndef IO_UART_STAT_BUSY_BIT
`define IO_UART_STAT_BUSY_BIT 0
`endif

module tb_led_uart_mmio;
  localparam int DIV = 8;
  localparam int XW  = `XLEN;
  localparam int AW  = `ADDR_W;
  localparam int LW  = `IO_LED_WIDTH;

  localparam logic [AW-1:0] LED_A  = AW'(`IO_BASE_ADDR + `IO_LED_OFFSET);
  localparam logic [AW-1:0] TX_A   = AW'(`IO_BASE_ADDR + `IO_UART_TX_OFFSET);
  localparam logic [AW-1:0] STAT_A = AW'(`IO_BASE_ADDR + `IO_UART_STAT_OFFSET);
  localparam logic [AW-1:0] BAD_A  = AW'(`IO_BASE_ADDR + 32'h0000_0040);

  logic          clk = 1'b0;
  logic          rst;
  logic          mmio_req;
  logic          mmio_we;
  logic [AW-1:0] mmio_addr;
  logic [XW-1:0] mmio_wdata;
  logic [XW-1:0] mmio_rdata;
  logic          mmio_ready;
  logic [LW-1:0] led_out;
  logic          uart_tx;

  led_uart_mmio #(.UART_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_req   (mmio_req),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .mmio_ready (mmio_ready),
    .led_out    (led_out),
    .uart_tx    (uart_tx)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [XW:0] exp_q[$];   // {is_read, expected rdata}
  logic        req_seen = 1'b0;
  logic        mon_en   = 1'b0;
  logic [15:0] tx_cnt   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] stat_val(input logic busy);
    logic [31:0] s;
    s = '0;
    s[`IO_UART_STAT_BUSY_BIT] = busy;
`ifdef LED_UART_TXCNT_EN
    s[31:16] = tx_cnt;
`endif
    return s;
  endfunction

  // Driver tasks
  task automatic drive(input logic we, input logic [AW-1:0] addr,
                       input logic [XW-1:0] wdata, input logic [XW-1:0] exp);
    mmio_req   = 1'b1;
    mmio_we    = we;
    mmio_addr  = addr;
    mmio_wdata = wdata;
    exp_q.push_back({~we, exp});
  endtask

  task automatic access(input logic we, input logic [AW-1:0] addr,
                        input logic [XW-1:0] wdata, input logic [XW-1:0] exp);
    @(negedge clk);
    drive(we, addr, wdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mmio_req = 1'b0;
      mmio_we  = 1'b0;
    end
  endtask

  // Scoreboard monitor: ready must follow every accepted request by one cycle
  always @(posedge clk) req_seen <= mmio_req && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      check("ready", {31'b0, mmio_ready}, {31'b0, req_seen});
      if (mmio_ready && req_seen) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          logic [XW:0] e;
          e = exp_q.pop_front();
          if (e[XW]) check("rdata", mmio_rdata, e[XW-1:0]);
        end
      end
    end
  end

  // Sends one byte and checks every bit-time of the line; optionally injects
  // a second TX write (which must be dropped) at sample index inject_at.
  task automatic run_frame(input logic [7:0] data, input int inject_at, input logic [7:0] inj);
    logic [9:0] fr;
    fr = {1'b1, data, 1'b0};
    access(1'b1, TX_A, {24'h0, data}, '0);
    tx_cnt++;
    access(1'b0, STAT_A, '0, stat_val(1'b1));
    for (int i = 0; i < 10 * DIV; i++) begin
      if (i > 0) begin
        @(negedge clk);
        mmio_req = 1'b0;
        if (i == inject_at) drive(1'b1, TX_A, {24'h0, inj}, '0);
      end
      check($sformatf("tx_bit%0d", i / DIV), {31'b0, uart_tx}, {31'b0, fr[i / DIV]});
    end
    idle(1);
    check("tx_idle_after", {31'b0, uart_tx}, 32'd1);
    access(1'b0, STAT_A, '0, stat_val(1'b0));
    idle(2);
    access(1'b0, STAT_A, '0, stat_val(1'b0));
    idle(1);
    check("tx_idle_late", {31'b0, uart_tx}, 32'd1);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [XW-1:0] wdata;
    logic [XW-1:0] exp_rdata;
    logic [LW-1:0] exp_led;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [LW-1:0] v;

    vecs[0] = '{1'b1, LED_A,  32'h0000_A5A5, 32'h0,         16'hA5A5};
    vecs[1] = '{1'b0, LED_A,  32'h0,         32'h0000_A5A5, 16'hA5A5};
    vecs[2] = '{1'b1, LED_A,  32'hDEAD_1234, 32'h0,         16'h1234};
    vecs[3] = '{1'b0, LED_A,  32'h0,         32'h0000_1234, 16'h1234};
    vecs[4] = '{1'b1, BAD_A,  32'hFFFF_FFFF, 32'h0,         16'h1234};
    vecs[5] = '{1'b0, BAD_A,  32'h0,         32'h0,         16'h1234};
    vecs[6] = '{1'b1, STAT_A, 32'hFFFF_FFFF, 32'h0,         16'h1234};
    vecs[7] = '{1'b0, STAT_A, 32'h0,         32'h0,         16'h1234};
    vecs[8] = '{1'b0, LED_A,  32'h0,         32'h0000_1234, 16'h1234};
    vecs[9] = '{1'b0, TX_A,   32'h0,         32'h0,         16'h1234};

    rst = 1'b1;
    mmio_req = 1'b0;
    mmio_we = 1'b0;
    mmio_addr = '0;
    mmio_wdata = '0;
    repeat (4) @(negedge clk);
    check("rst_led",   {16'b0, led_out}, 32'h0);
    check("rst_tx",    {31'b0, uart_tx}, 32'd1);
    check("rst_ready", {31'b0, mmio_ready}, 32'd0);
    check("rst_rdata", mmio_rdata, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    access(1'b0, STAT_A, '0, stat_val(1'b0));
    idle(1);

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      idle(1);
      check($sformatf("vec%0d_led", i), {16'b0, led_out}, {16'b0, vecs[i].exp_led});
    end

    for (int i = 0; i < 20; i++) begin
      v = LW'($urandom_range(0, 65535));
      access(1'b1, LED_A, {16'h0, v}, '0);
      access(1'b0, LED_A, '0, {16'h0, v});
      idle(1);
      check("rand_led", {16'b0, led_out}, {16'b0, v});
    end

    run_frame(8'h55, -1, 8'h00);
    run_frame(8'h55, 20, 8'hFF);
    run_frame(8'hA3, 10 * DIV - 1, 8'h0F);

    // Reset mid-frame, with a same-edge LED write that must be ignored
    access(1'b1, LED_A, 32'h0000_7E81, '0);
    access(1'b0, LED_A, '0, 32'h0000_7E81);
    access(1'b1, TX_A, 32'h0000_0000, '0);
    idle(20);
    check("pre_rst_tx", {31'b0, uart_tx}, 32'd0);
    mmio_req = 1'b1;
    mmio_we = 1'b1;
    mmio_addr = LED_A;
    mmio_wdata = 32'h0000_BEEF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mmio_req = 1'b0;
    mmio_we = 1'b0;
    tx_cnt = '0;
    check("midrst_tx",    {31'b0, uart_tx}, 32'd1);
    check("midrst_led",   {16'b0, led_out}, 32'h0);
    check("midrst_rdata", mmio_rdata, 32'h0);
    access(1'b0, STAT_A, '0, stat_val(1'b0));
    access(1'b0, LED_A, '0, 32'h0);
    access(1'b0, TX_A, '0, 32'h0);
    access(1'b0, BAD_A, '0, 32'h0);
    idle(3);
    check("post_rst_tx", {31'b0, uart_tx}, 32'd1);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
